// File: rtl/enc_pkg.sv
// enc_pkg: shared widths and encode helpers for encoder_4x2_stream
package enc_pkg;
    localparam int D_W = 4;
    localparam int Y_W = 2;

    function automatic logic [Y_W-1:0] prio_enc(input logic [D_W-1:0] v);
        return v[3] ? 2'd3 : v[2] ? 2'd2 : v[1] ? 2'd1 : 2'd0;
    endfunction

    function automatic logic multi_hot(input logic [D_W-1:0] v);
        return (v & (v - 4'd1)) != '0;
    endfunction
endpackage

// File: rtl/enc_fifo.sv
// enc_fifo: DEPTH x W synchronous FIFO with a registered head that holds its last value when empty
module enc_fifo #(
    parameter int DEPTH = 4,
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         valid,
    output logic         ready
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    logic [W-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr, rd_nxt;
    logic [CW-1:0] count, count_nxt;
    logic do_push, do_pop;

    assign valid = count != '0;
    assign ready = count != CW'(DEPTH);
    assign do_push = push && ready;
    assign do_pop = pop && valid;
    assign rd_nxt = rd_ptr + AW'(do_pop);
    assign count_nxt = count + CW'(do_push) - CW'(do_pop);

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    // The head slot may be written this very cycle, so forward din into it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
            dout <= '0;
        end else begin
            wr_ptr <= wr_ptr + AW'(do_push);
            rd_ptr <= rd_nxt;
            count <= count_nxt;
            if (count_nxt != '0) dout <= (do_push && rd_nxt == wr_ptr) ? din : mem[rd_nxt];
        end
    end
endmodule

// File: rtl/encoder_4x2_stream.sv
// encoder_4x2_stream: registered 4-to-2 priority encoder feeding an output FIFO with a saturating drop counter
// Optional sticky multi-hot flag on err when ENC_MULTIHOT_CHECK_EN is defined.
module encoder_4x2_stream
    import enc_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [D_W-1:0]   d,
    output logic             in_ready,
    output logic [Y_W-1:0]   y,
    output logic             y_valid,
    input  logic             y_ready,
    output logic             err,
    output logic [CNT_W-1:0] drop_cnt
);
    logic req, acc;

    assign req = en && (d != '0);
    assign acc = req && in_ready;

    enc_fifo #(.DEPTH(DEPTH), .W(Y_W)) u_fifo (
        .clk(clk),
        .rst_n(rst_n),
        .push(acc),
        .din(prio_enc(d)),
        .pop(y_ready),
        .dout(y),
        .valid(y_valid),
        .ready(in_ready)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) drop_cnt <= '0;
        else if (req && !in_ready && drop_cnt != '1) drop_cnt <= drop_cnt + 1'b1;
    end

`ifdef ENC_MULTIHOT_CHECK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) err <= 1'b0;
        else if (acc && multi_hot(d)) err <= 1'b1;
    end
`else
    assign err = 1'b0;
`endif
endmodule
